// File: rtl/fft_pkg.sv
// Shared FFT BRAM-interface package: FSM state encoding, clogb2 and bit-reverse helpers.
// Used by the load-side and store-side BRAM interfaces and by fft_addr_gen.
// Contents: fft_state_e, clogb2(), bit_rev().
package fft_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_DONE  = 2'd2
    } fft_state_e;

    // Number of bits needed to represent value (clogb2(7) = 3, clogb2(1023) = 10).
    function automatic int clogb2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 32; i++) begin
            if ((value >> i) != 0) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

    // Reverse the low aw bits of v; bits above aw come back as zero.
    // Shift/mask form keeps every index constant, so any aw up to 32 works.
    function automatic logic [31:0] bit_rev(input logic [31:0] v, input int aw);
        logic [31:0] r;
        r = '0;
        for (int i = 0; i < 32; i++) begin
            if (i < aw) begin
                r = r | (((v >> (aw - 1 - i)) & 32'd1) << i);
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/fft_addr_gen.sv
// Frame sample counter with linear or bit-reversed address decode (shared by load and store sides).
// Latency: o_cnt/o_addr reflect the counter register; o_addr is a pure decode of o_cnt.
// Backpressure: none; the caller increments only on accepted samples. i_clr beats i_inc.
// Ports: clk, rst_n, i_clr (zero the counter), i_inc (count one sample), o_cnt, o_addr.
module fft_addr_gen
    import fft_pkg::*;
#(
    parameter int AW          = 10,
    parameter int BIT_REVERSE = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_clr,
    input  logic          i_inc,
    output logic [AW-1:0] o_cnt,
    output logic [AW-1:0] o_addr
);

    logic [AW-1:0] cnt_q;
    logic [AW-1:0] cnt_d;

    // The depth is a power of two, so the natural wrap of the adder returns cnt to 0
    // after the last sample of a frame.
    always_comb begin
        cnt_d = cnt_q;
        if (i_clr) begin
            cnt_d = '0;
        end else if (i_inc) begin
            cnt_d = cnt_q + AW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign o_cnt  = cnt_q;
    assign o_addr = (BIT_REVERSE != 0) ? AW'(bit_rev(32'(cnt_q), AW)) : cnt_q;

endmodule

// File: rtl/store_bram_if.sv
// Store-side BRAM interface: writes one DATA_DEPTH-sample frame into BRAM, linear or bit-reversed.
// Latency: an accepted sample (i_valid & o_ready) is presented on o_enb/o_web/o_addrb/o_dinb one cycle later.
// Backpressure: o_ready is high only in WRITE and comes from a register, so there is no path from i_valid.
// Ports: i_start/i_abort frame control; i_data/i_valid/o_ready sample stream;
//        o_addrb/o_dinb/o_enb/o_web BRAM port B; o_busy/o_done frame status. All outputs registered.
module store_bram_if
    import fft_pkg::*;
#(
    parameter int DATA_WIDTH  = 18,
    parameter int DATA_DEPTH  = 1024,
    parameter int BIT_REVERSE = 1,
    localparam int AW         = clogb2(DATA_DEPTH - 1)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_start,
    input  logic                  i_abort,
    input  logic [DATA_WIDTH-1:0] i_data,
    input  logic                  i_valid,
    output logic                  o_ready,
    output logic [AW-1:0]         o_addrb,
    output logic [DATA_WIDTH-1:0] o_dinb,
    output logic                  o_enb,
    output logic                  o_web,
    output logic                  o_busy,
    output logic                  o_done
);

    fft_state_e            state_q, state_d;
    logic                  ready_q, ready_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  wr_q, wr_d;
    logic [AW-1:0]         addrb_q, addrb_d;
    logic [DATA_WIDTH-1:0] dinb_q, dinb_d;

    logic                  accept;
    logic                  cnt_clr;
    logic [AW-1:0]         cnt;
    logic [AW-1:0]         addr;
    logic                  last;

    assign accept = i_valid && ready_q;
    assign last   = (cnt == AW'(DATA_DEPTH - 1));

    fft_addr_gen #(
        .AW          (AW),
        .BIT_REVERSE (BIT_REVERSE)
    ) u_addr_gen (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_clr  (cnt_clr),
        .i_inc  (accept),
        .o_cnt  (cnt),
        .o_addr (addr)
    );

    always_comb begin
        state_d = state_q;
        cnt_clr = 1'b0;
        case (state_q)
            ST_IDLE: begin
                // Abort in the same cycle as start keeps the block idle.
                if (i_start && !i_abort) begin
                    state_d = ST_WRITE;
                    cnt_clr = 1'b1;
                end
            end
            ST_WRITE: begin
                // A sample accepted alongside abort is still written, but the frame ends.
                if (i_abort) begin
                    state_d = ST_IDLE;
                    cnt_clr = 1'b1;
                end else if (accept && last) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                cnt_clr = i_abort;
            end
            default: begin
                state_d = ST_IDLE;
                cnt_clr = 1'b1;
            end
        endcase
    end

    // Status outputs are decoded from the next state so they line up with the state register.
    always_comb begin
        ready_d = (state_d == ST_WRITE);
        busy_d  = (state_d != ST_IDLE);
        done_d  = (state_d == ST_DONE);
        wr_d    = accept;
        addrb_d = accept ? addr : addrb_q;
        dinb_d  = accept ? i_data : dinb_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            ready_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            wr_q    <= 1'b0;
            addrb_q <= '0;
            dinb_q  <= '0;
        end else begin
            state_q <= state_d;
            ready_q <= ready_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            wr_q    <= wr_d;
            addrb_q <= addrb_d;
            dinb_q  <= dinb_d;
        end
    end

    assign o_ready = ready_q;
    assign o_busy  = busy_q;
    assign o_done  = done_q;
    assign o_enb   = wr_q;
    assign o_web   = wr_q;
    assign o_addrb = addrb_q;
    assign o_dinb  = dinb_q;

endmodule
